// File: rtl/custom_ahb_busmatrix_decoder.sv
// Output-side address decoder for one bus-matrix master port.
// Decodes the address phase into one-hot slave selects, or the default slave
// on no hit. Registers the data-phase owner and muxes the owner's response
// back upstream.
// Optional feature macro: DECODER_REMAP_EN adds a REMAP input. When REMAP is 1,
// the slave 0 and slave 1 targets swap.
module custom_ahb_busmatrix_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hF000_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELD,
  input  logic [31:0] HADDRD,
  input  logic [1:0]  HTRANSD,
  input  logic        HREADY,
`ifdef DECODER_REMAP_EN
  input  logic        REMAP,
`endif
  output logic [2:0]  HSELM,
  output logic        HSELDEF,
  input  logic [2:0]  HREADYOUTM,
  input  logic [5:0]  HRESPM,
  input  logic [95:0] HRDATAM,
  input  logic        HREADYOUTDEF,
  input  logic [1:0]  HRESPDEF,
  output logic        HREADYOUTD,
  output logic [1:0]  HRESPD,
  output logic [31:0] HRDATAD
);

  localparam int unsigned NUM_SLV = 3;
  localparam int unsigned DW      = 32;

  logic [NUM_SLV-1:0] region_hit;
  logic [NUM_SLV-1:0] prio_sel;
  logic [NUM_SLV-1:0] tgt_sel;
  logic               remap_on;
  logic [NUM_SLV:0]   dsel;

  // Transfer type is forwarded to the slaves elsewhere; not needed for decode.
  logic unused_htrans;
  assign unused_htrans = ^HTRANSD;

`ifdef DECODER_REMAP_EN
  assign remap_on = REMAP;
`else
  assign remap_on = 1'b0;
`endif

  // Address decode: region match, lowest-index priority, optional target swap.
  always_comb begin
    region_hit[0] = (HADDRD & S0_MASK) == S0_BASE;
    region_hit[1] = (HADDRD & S1_MASK) == S1_BASE;
    region_hit[2] = (HADDRD & S2_MASK) == S2_BASE;

    prio_sel = '0;
    if (region_hit[0])      prio_sel = 3'b001;
    else if (region_hit[1]) prio_sel = 3'b010;
    else if (region_hit[2]) prio_sel = 3'b100;

    tgt_sel = prio_sel;
    if (remap_on) tgt_sel = {prio_sel[2], prio_sel[0], prio_sel[1]};

    HSELM   = HSELD ? tgt_sel : '0;
    HSELDEF = HSELD & ~|region_hit;
  end

  // Data-phase owner: advances only when the address phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= '0;
    end else if (HREADY) begin
      dsel <= {HSELDEF, HSELM};
    end
  end

  // Response mux from the current data-phase owner; an idle bus reports ready/OKAY.
  always_comb begin
    HREADYOUTD = 1'b1;
    HRESPD     = 2'b00;
    HRDATAD    = '0;
    if (dsel[NUM_SLV]) begin
      HREADYOUTD = HREADYOUTDEF;
      HRESPD     = HRESPDEF;
    end
    for (int n = 0; n < NUM_SLV; n++) begin
      if (dsel[n]) begin
        HREADYOUTD = HREADYOUTM[n];
        HRESPD     = HRESPM[2*n +: 2];
        HRDATAD    = HRDATAM[DW*n +: DW];
      end
    end
  end

endmodule

// File: tb/tb_custom_ahb_busmatrix_decoder.sv
// Self-checking bench for custom_ahb_busmatrix_decoder (optionally DECODER_REMAP_EN).
module tb_custom_ahb_busmatrix_decoder;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELD;
  logic [31:0] HADDRD;
  logic [1:0]  HTRANSD;
  logic        HREADY;
  logic        REMAP;
  logic [2:0]  HSELM;
  logic        HSELDEF;
  logic [2:0]  HREADYOUTM;
  logic [5:0]  HRESPM;
  logic [95:0] HRDATAM;
  logic        HREADYOUTDEF;
  logic [1:0]  HRESPDEF;
  logic        HREADYOUTD;
  logic [1:0]  HRESPD;
  logic [31:0] HRDATAD;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;
  int m_owner = -1;   // -1 none, 0..2 slave, 3 default

  always #5 HCLK = ~HCLK;

  custom_ahb_busmatrix_decoder dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELD(HSELD), .HADDRD(HADDRD),
    .HTRANSD(HTRANSD), .HREADY(HREADY),
`ifdef DECODER_REMAP_EN
    .REMAP(REMAP),
`endif
    .HSELM(HSELM), .HSELDEF(HSELDEF), .HREADYOUTM(HREADYOUTM),
    .HRESPM(HRESPM), .HRDATAM(HRDATAM), .HREADYOUTDEF(HREADYOUTDEF),
    .HRESPDEF(HRESPDEF), .HREADYOUTD(HREADYOUTD), .HRESPD(HRESPD),
    .HRDATAD(HRDATAD)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: which target the current address phase selects (-1 none, 3 default).
  function automatic int exp_target();
    logic [31:0] base [3];
    logic [31:0] mask [3];
    bit remap;
    base = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000};
    mask = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
`ifdef DECODER_REMAP_EN
    remap = REMAP;
`else
    remap = 1'b0;
`endif
    if (!HSELD) return -1;
    for (int i = 0; i < 3; i++)
      if ((HADDRD & mask[i]) == base[i]) return (remap && i < 2) ? 1 - i : i;
    return 3;
  endfunction

  // Model: data-phase owner follows the completed address phase.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) m_owner = -1;
    else if (HREADY) m_owner = exp_target();
  end

  // Compare process: checks every output against the model each cycle.
  always @(negedge HCLK) begin
    if (cmp_en) begin
      int t;
      logic [2:0] e_sel;
      logic        e_rdy;
      logic [1:0]  e_resp;
      logic [31:0] e_data;
      t = exp_target();
      e_sel = (t >= 0 && t < 3) ? 3'(1 << t) : 3'b000;
      chk("hselm", 64'(HSELM), 64'(e_sel));
      chk("hseldef", 64'(HSELDEF), 64'(t == 3));
      e_rdy = 1'b1; e_resp = 2'b00; e_data = 32'h0;
      if (m_owner == 3) begin
        e_rdy = HREADYOUTDEF; e_resp = HRESPDEF;
      end else if (m_owner >= 0) begin
        e_rdy  = HREADYOUTM[m_owner];
        e_resp = HRESPM[2*m_owner +: 2];
        e_data = HRDATAM[32*m_owner +: 32];
      end
      chk("hreadyoutd", 64'(HREADYOUTD), 64'(e_rdy));
      chk("hrespd", 64'(HRESPD), 64'(e_resp));
      chk("hrdatad", 64'(HRDATAD), 64'(e_data));
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; HSELD = 1'b0; HADDRD = 32'h0; HTRANSD = 2'b00; HREADY = 1'b1;
    REMAP = 1'b0; HREADYOUTM = 3'b111; HRESPM = 6'h0;
    HRDATAM = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    HREADYOUTDEF = 1'b1; HRESPDEF = 2'b00;
    cmp_en = 1'b1;

    // Reset state
    @(negedge HCLK);
    chk("rst_ready", 64'(HREADYOUTD), 64'h1);
    chk("rst_resp", 64'(HRESPD), 64'h0);
    chk("rst_data", 64'(HRDATAD), 64'h0);
    step(); #1 HRESETn = 1'b1;

    // Slave 1 access
    step();
    HSELD = 1'b1; HADDRD = 32'h2000_0010; HTRANSD = 2'b10; HREADY = 1'b1;
    @(negedge HCLK);
    chk("s1_sel", 64'(HSELM), 64'h2);
    step();
    HSELD = 1'b1; HADDRD = 32'h8000_0000; HTRANSD = 2'b10;
    @(negedge HCLK);
    chk("s1_data", 64'(HRDATAD), 64'hA5A5_0001);
    chk("def_sel", 64'(HSELDEF), 64'h1);
    chk("def_selm", 64'(HSELM), 64'h0);

    // Two-cycle ERROR from default slave
    step();
    HREADYOUTDEF = 1'b0; HRESPDEF = 2'b01; HREADY = 1'b0; HTRANSD = 2'b00;
    @(negedge HCLK);
    chk("err_c1", 64'({HREADYOUTD, HRESPD}), 64'h1);
    step();
    HREADYOUTDEF = 1'b1; HRESPDEF = 2'b01; HREADY = 1'b1;
    HSELD = 1'b1; HADDRD = 32'h0000_0040; HTRANSD = 2'b00;
    @(negedge HCLK);
    chk("err_c2", 64'({HREADYOUTD, HRESPD}), 64'h5);
    chk("idle_dec", 64'(HSELM), 64'h1);

    // Slave 0 wait states while address moves to slave 2
    step();
    HRESPDEF = 2'b00; HREADYOUTM = 3'b110; HREADY = 1'b0;
    HADDRD = 32'h4000_0000; HTRANSD = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("ws_ready", 64'(HREADYOUTD), 64'h0);
      chk("ws_data", 64'(HRDATAD), 64'hA5A5_0000);
      step();
    end
    HREADYOUTM = 3'b111; HREADY = 1'b1;
    @(negedge HCLK);
    chk("ws_done", 64'(HREADYOUTD), 64'h1);
    step();
    HREADYOUTM = 3'b011; HREADY = 1'b0; HSELD = 1'b0;
    @(negedge HCLK);
    chk("s2_data", 64'(HRDATAD), 64'hA5A5_0002);
    chk("s2_ready", 64'(HREADYOUTD), 64'h0);

    // Async reset mid slave-2 data phase
    step();
    #1 HRESETn = 1'b0;
    #1;
    chk("arst_ready", 64'(HREADYOUTD), 64'h1);
    chk("arst_data", 64'(HRDATAD), 64'h0);
    step();
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("no_resume", 64'(HREADYOUTD), 64'h1);

`ifdef DECODER_REMAP_EN
    // Remap swaps S0/S1; toggling during data phase leaves owner alone
    step();
    REMAP = 1'b1; HSELD = 1'b1; HADDRD = 32'h0000_0100; HREADY = 1'b1; HREADYOUTM = 3'b111;
    @(negedge HCLK);
    chk("remap_sel", 64'(HSELM), 64'h2);
    step();
    REMAP = 1'b0; HREADY = 1'b0; HSELD = 1'b0;
    @(negedge HCLK);
    chk("remap_owner", 64'(HRDATAD), 64'hA5A5_0001);
    step();
    HREADY = 1'b1;
`endif

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [3:0] nib;
      step();
      case ($urandom_range(0, 4))
        0: nib = 4'h0;
        1: nib = 4'h2;
        2: nib = 4'h4;
        default: nib = 4'($urandom_range(0, 15));
      endcase
      HSELD = ($urandom_range(0, 3) != 0);
      HADDRD = {nib, 28'($urandom)};
      HTRANSD = 2'($urandom);
      HREADY = ($urandom_range(0, 3) != 0);
      REMAP = 1'($urandom);
      HREADYOUTM = 3'($urandom);
      HRESPM = {1'b0, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom)};
      HRDATAM = {32'($urandom), 32'($urandom), 32'($urandom)};
      HREADYOUTDEF = 1'($urandom);
      HRESPDEF = {1'b0, 1'($urandom)};
    end
    @(negedge HCLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
